// File: rtl/crop_uncrop_pad_pkg.sv
// Shared definitions for the crop / uncrop stages: default frame geometry,
// fill value and the two-state stream FSM encoding.
package crop_pkg;

    // Default geometry, shared with crop_filter so both ends agree.
    localparam int DEF_PIXEL_BIT_WIDTH  = 12;
    localparam int DEF_IN_ROWS          = 40;
    localparam int DEF_IN_COLS          = 40;
    localparam int DEF_OUT_ROWS         = 20;
    localparam int DEF_OUT_COLS         = 20;
    localparam int DEF_IMG_ROW_BITWIDTH = 10;
    localparam int DEF_IMG_COL_BITWIDTH = 10;

    // Pixel value emitted outside the crop box.
    localparam int DEF_FILL_VALUE       = 0;

    // Stream FSM states.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } crop_state_e;

    // Plain constants for code that keeps state in a logic vector.
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

endpackage

// File: rtl/crop_uncrop_pad_frame_raster_counter.sv
// Raster (x,y) position counter for a full frame. Advances on en, wraps x at
// COLS-1 into the next row, wraps y at ROWS-1 back to the top, and flags the
// last pixel of the frame combinationally.
module frame_raster_counter #(
    parameter int COLS = 40,
    parameter int ROWS = 40,
    parameter int XW   = 10,
    parameter int YW   = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    logic x_at_end;
    logic y_at_end;

    assign x_at_end = (x == XW'(COLS - 1));
    assign y_at_end = (y == YW'(ROWS - 1));
    assign last     = x_at_end && y_at_end;

    // Step through the frame in raster order, one position per enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x_at_end) begin
                x <= '0;
                y <= y_at_end ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

endmodule

// File: rtl/crop_uncrop_pad.sv
// Uncrop stage: rebuilds a full IN_ROWSxIN_COLS frame from a cropped
// OUT_ROWSxOUT_COLS stream, placing the crop box at corner (X1,Y1) and filling
// everything else with FILL_VALUE.
//
// Handshakes: every *_TVALID/*_TREADY pair transfers on a posedge where both
// are high; a source holds VALID and DATA stable until that happens, and
// pixel_out holds TDATA/TVALID while pixel_out_TREADY is low.
module crop_uncrop_pad
    import crop_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH  = DEF_PIXEL_BIT_WIDTH,
    parameter int IN_ROWS          = DEF_IN_ROWS,
    parameter int IN_COLS          = DEF_IN_COLS,
    parameter int OUT_ROWS         = DEF_OUT_ROWS,
    parameter int OUT_COLS         = DEF_OUT_COLS,
    parameter int IMG_ROW_BITWIDTH = DEF_IMG_ROW_BITWIDTH,
    parameter int IMG_COL_BITWIDTH = DEF_IMG_COL_BITWIDTH,
    parameter logic [PIXEL_BIT_WIDTH-1:0] FILL_VALUE = PIXEL_BIT_WIDTH'(DEF_FILL_VALUE)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [PIXEL_BIT_WIDTH-1:0]  pixel_in_TDATA,
    input  logic                        pixel_in_TVALID,
    output logic                        pixel_in_TREADY,
    input  logic [IMG_ROW_BITWIDTH-1:0] crop_Y1_TDATA,
    input  logic                        crop_Y1_TVALID,
    output logic                        crop_Y1_TREADY,
    input  logic [IMG_COL_BITWIDTH-1:0] crop_X1_TDATA,
    input  logic                        crop_X1_TVALID,
    output logic                        crop_X1_TREADY,
    output logic [PIXEL_BIT_WIDTH-1:0]  pixel_out_TDATA,
    output logic                        pixel_out_TVALID,
    input  logic                        pixel_out_TREADY,
    output logic                        pixel_out_TLAST,
    output logic                        clamp_flag,
    output logic [0:0]                  state_dbg
);

    localparam int CW = IMG_COL_BITWIDTH;
    localparam int RW = IMG_ROW_BITWIDTH;

    // Largest legal corners; compared one bit wider so nothing overflows.
    localparam logic [CW:0] X_MAX = (CW + 1)'(IN_COLS - OUT_COLS);
    localparam logic [RW:0] Y_MAX = (RW + 1)'(IN_ROWS - OUT_ROWS);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] x1_q;
    logic [RW-1:0] y1_q;
    logic          have_x_q, have_x_d;
    logic          have_y_q, have_y_d;
    logic          rdy_x_q, rdy_y_q;
    logic          clamp_q;

    logic [CW-1:0] x;
    logic [RW-1:0] y;
    logic          last;

    logic          cap_x, cap_y;
    logic          x_clamp, y_clamp;
    logic [CW-1:0] x1_capt;
    logic [RW-1:0] y1_capt;
    logic          out_hs;
    logic          frame_done;
    logic          in_box;

    logic [CW:0]   x_ext, x_lo, x_hi;
    logic [RW:0]   y_ext, y_lo, y_hi;

    // Corner capture happens only in IDLE; READY is already low elsewhere.
    assign cap_x = (state_q == ST_IDLE) && crop_X1_TVALID && rdy_x_q;
    assign cap_y = (state_q == ST_IDLE) && crop_Y1_TVALID && rdy_y_q;

    assign x_clamp = ({1'b0, crop_X1_TDATA} > X_MAX);
    assign y_clamp = ({1'b0, crop_Y1_TDATA} > Y_MAX);
    assign x1_capt = x_clamp ? X_MAX[CW-1:0] : crop_X1_TDATA;
    assign y1_capt = y_clamp ? Y_MAX[RW-1:0] : crop_Y1_TDATA;

    assign out_hs     = pixel_out_TVALID && pixel_out_TREADY;
    assign frame_done = out_hs && last;

    frame_raster_counter #(
        .COLS (IN_COLS),
        .ROWS (IN_ROWS),
        .XW   (CW),
        .YW   (RW)
    ) u_raster (
        .clk   (clk),
        .reset (reset),
        .en    (out_hs),
        .x     (x),
        .y     (y),
        .last  (last)
    );

    // Box bounds in one-bit-wider arithmetic.
    assign x_ext  = {1'b0, x};
    assign x_lo   = {1'b0, x1_q};
    assign x_hi   = x_lo + (CW + 1)'(OUT_COLS - 1);
    assign y_ext  = {1'b0, y};
    assign y_lo   = {1'b0, y1_q};
    assign y_hi   = y_lo + (RW + 1)'(OUT_ROWS - 1);
    assign in_box = (x_ext >= x_lo) && (x_ext <= x_hi) &&
                    (y_ext >= y_lo) && (y_ext <= y_hi);

    // Next-state logic: collect both corners, then stream one frame.
    always_comb begin
        state_d  = state_q;
        have_x_d = have_x_q;
        have_y_d = have_y_q;
        case (state_q)
            ST_IDLE: begin
                if (cap_x) have_x_d = 1'b1;
                if (cap_y) have_y_d = 1'b1;
                if (have_x_q && have_y_q) state_d = ST_STREAM;
            end
            default: begin
                if (frame_done) begin
                    have_x_d = 1'b0;
                    have_y_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
        endcase
    end

    // State, corner registers, registered corner READYs and sticky clamp flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            x1_q     <= '0;
            y1_q     <= '0;
            have_x_q <= 1'b0;
            have_y_q <= 1'b0;
            rdy_x_q  <= 1'b0;
            rdy_y_q  <= 1'b0;
            clamp_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            have_x_q <= have_x_d;
            have_y_q <= have_y_d;
            rdy_x_q  <= (state_d == ST_IDLE) && !have_x_d;
            rdy_y_q  <= (state_d == ST_IDLE) && !have_y_d;
            if (cap_x) x1_q <= x1_capt;
            if (cap_y) y1_q <= y1_capt;
            if ((cap_x && x_clamp) || (cap_y && y_clamp)) clamp_q <= 1'b1;
        end
    end

    // Output mux: pass the cropped stream through inside the box, fill outside.
    always_comb begin
        pixel_out_TDATA  = '0;
        pixel_out_TVALID = 1'b0;
        pixel_in_TREADY  = 1'b0;
        if (state_q == ST_STREAM) begin
            if (in_box) begin
                pixel_out_TDATA  = pixel_in_TDATA;
                pixel_out_TVALID = pixel_in_TVALID;
                pixel_in_TREADY  = pixel_out_TREADY;
            end else begin
                pixel_out_TDATA  = FILL_VALUE;
                pixel_out_TVALID = 1'b1;
            end
        end
    end

    assign pixel_out_TLAST = (state_q == ST_STREAM) && last;
    assign crop_X1_TREADY  = rdy_x_q;
    assign crop_Y1_TREADY  = rdy_y_q;
    assign clamp_flag      = clamp_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_crop_uncrop_pad.sv
// Self-checking bench for crop_uncrop_pad on a 4x5 frame with a 2x2 box.
module tb_crop_uncrop_pad;
  import crop_pkg::*;

  localparam int PW = 12;
  localparam int IR = 4;
  localparam int IC = 5;
  localparam int OR = 2;
  localparam int OC = 2;
  localparam int RB = 10;
  localparam int CB = 10;
  localparam int NPIX = IR * IC;
  localparam logic [PW-1:0] FILL = 12'hFFF;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [PW-1:0] pixel_in_TDATA;
  logic          pixel_in_TVALID;
  logic          pixel_in_TREADY;
  logic [RB-1:0] crop_Y1_TDATA;
  logic          crop_Y1_TVALID;
  logic          crop_Y1_TREADY;
  logic [CB-1:0] crop_X1_TDATA;
  logic          crop_X1_TVALID;
  logic          crop_X1_TREADY;
  logic [PW-1:0] pixel_out_TDATA;
  logic          pixel_out_TVALID;
  logic          pixel_out_TREADY;
  logic          pixel_out_TLAST;
  logic          clamp_flag;
  logic [0:0]    state_dbg;

  crop_uncrop_pad #(
    .PIXEL_BIT_WIDTH  (PW),
    .IN_ROWS          (IR),
    .IN_COLS          (IC),
    .OUT_ROWS         (OR),
    .OUT_COLS         (OC),
    .IMG_ROW_BITWIDTH (RB),
    .IMG_COL_BITWIDTH (CB),
    .FILL_VALUE       (FILL)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .pixel_in_TDATA   (pixel_in_TDATA),
    .pixel_in_TVALID  (pixel_in_TVALID),
    .pixel_in_TREADY  (pixel_in_TREADY),
    .crop_Y1_TDATA    (crop_Y1_TDATA),
    .crop_Y1_TVALID   (crop_Y1_TVALID),
    .crop_Y1_TREADY   (crop_Y1_TREADY),
    .crop_X1_TDATA    (crop_X1_TDATA),
    .crop_X1_TVALID   (crop_X1_TVALID),
    .crop_X1_TREADY   (crop_X1_TREADY),
    .pixel_out_TDATA  (pixel_out_TDATA),
    .pixel_out_TVALID (pixel_out_TVALID),
    .pixel_out_TREADY (pixel_out_TREADY),
    .pixel_out_TLAST  (pixel_out_TLAST),
    .clamp_flag       (clamp_flag),
    .state_dbg        (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [PW-1:0] exp_q[$];
  bit            box_q[$];
  logic [PW-1:0] pix_a[4];
  bit            clamp_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: full raster, fill outside the (clamped) box, cropped
  // pixels in raster order inside it.
  task automatic build_model(input int x1, input int y1);
    int cx, cy;
    bit inb;
    cx = (x1 > IC - OC) ? IC - OC : x1;
    cy = (y1 > IR - OR) ? IR - OR : y1;
    if (x1 > IC - OC || y1 > IR - OR) clamp_exp = 1'b1;
    exp_q.delete();
    box_q.delete();
    for (int r = 0; r < IR; r++) begin
      for (int c = 0; c < IC; c++) begin
        inb = (c >= cx) && (c < cx + OC) && (r >= cy) && (r < cy + OR);
        box_q.push_back(inb);
        exp_q.push_back(inb ? pix_a[(r - cy) * OC + (c - cx)] : FILL);
      end
    end
  endtask

  task automatic rand_pix();
    for (int i = 0; i < 4; i++) pix_a[i] = PW'($urandom_range(12'hFFE));
  endtask

  // ---------------- driver tasks ----------------
  // Offer Y1 first; X1 follows 'lead' cycles after Y1 is taken (lead=0: together).
  task automatic send_corners(input int x1, input int y1, input int lead);
    int cyc, since;
    bit gx, gy, hx, hy;
    cyc = 0; since = 0; gx = 0; gy = 0;
    crop_X1_TDATA  = CB'(x1);
    crop_Y1_TDATA  = RB'(y1);
    crop_Y1_TVALID = 1'b1;
    if (lead == 0) crop_X1_TVALID = 1'b1;
    while (!(gx && gy) && cyc < 60) begin
      @(negedge clk);
      hx = crop_X1_TVALID && crop_X1_TREADY;
      hy = crop_Y1_TVALID && crop_Y1_TREADY;
      @(posedge clk); #1;
      if (hx) begin gx = 1; crop_X1_TVALID = 1'b0; end
      if (hy) begin gy = 1; crop_Y1_TVALID = 1'b0; end
      if (gy && !gx && !crop_X1_TVALID) begin
        since++;
        if (since >= lead) crop_X1_TVALID = 1'b1;
      end
      cyc++;
    end
    check("corner_accept", {30'd0, gx, gy}, 32'd3);
  endtask

  // Stream one frame against exp_q/box_q. abort_at >= 0 pulls reset at that
  // output index; watch_x checks that a pending X1 is held off mid-frame.
  task automatic run_frame(input int rdy_pct, input int gap_pct, input int abort_at, input bit watch_x);
    int out_idx, in_idx, cyc;
    bit in_hold, prev_stall, out_hs, in_hs, aborted;
    logic [PW-1:0] prev_data;
    out_idx = 0; in_idx = 0; cyc = 0;
    in_hold = 0; prev_stall = 0; aborted = 0; prev_data = '0;
    pixel_in_TVALID = 1'b0;
    check("idle_tvalid", {31'd0, pixel_out_TVALID}, 32'd0);
    @(posedge clk); #1;
    while (out_idx < NPIX && cyc < 500) begin
      if (out_idx == abort_at) begin
        reset = 1'b0;
        #1;
        check("rst_tvalid", {31'd0, pixel_out_TVALID}, 32'd0);
        check("rst_tdata",  {20'd0, pixel_out_TDATA},  32'd0);
        check("rst_tlast",  {31'd0, pixel_out_TLAST},  32'd0);
        check("rst_in_rdy", {31'd0, pixel_in_TREADY},  32'd0);
        check("rst_x_rdy",  {31'd0, crop_X1_TREADY},   32'd0);
        check("rst_y_rdy",  {31'd0, crop_Y1_TREADY},   32'd0);
        check("rst_clamp",  {31'd0, clamp_flag},       32'd0);
        aborted = 1;
        break;
      end
      pixel_out_TREADY = ($urandom_range(99) < rdy_pct);
      if (!in_hold) begin
        if (in_idx < 4) begin
          pixel_in_TVALID = ($urandom_range(99) >= gap_pct);
          pixel_in_TDATA  = pix_a[in_idx];
        end else begin
          pixel_in_TVALID = 1'b1;
          pixel_in_TDATA  = PW'($urandom);
        end
      end
      @(negedge clk);
      if (prev_stall) begin
        check("stall_valid", {31'd0, pixel_out_TVALID}, 32'd1);
        check("stall_data",  {20'd0, pixel_out_TDATA}, {20'd0, prev_data});
      end
      check($sformatf("tvalid[%0d]", out_idx), {31'd0, pixel_out_TVALID},
            box_q[out_idx] ? {31'd0, pixel_in_TVALID} : 32'd1);
      check($sformatf("in_tready[%0d]", out_idx), {31'd0, pixel_in_TREADY},
            {31'd0, box_q[out_idx] && pixel_out_TREADY});
      if (pixel_out_TVALID) begin
        check($sformatf("tdata[%0d]", out_idx), {20'd0, pixel_out_TDATA}, {20'd0, exp_q[out_idx]});
        check($sformatf("tlast[%0d]", out_idx), {31'd0, pixel_out_TLAST}, {31'd0, out_idx == NPIX - 1});
      end
      if (watch_x) check("x1_rdy_stream", {31'd0, crop_X1_TREADY}, 32'd0);
      out_hs     = pixel_out_TVALID && pixel_out_TREADY;
      in_hs      = pixel_in_TVALID && pixel_in_TREADY;
      prev_stall = pixel_out_TVALID && !pixel_out_TREADY;
      prev_data  = pixel_out_TDATA;
      in_hold    = pixel_in_TVALID && !in_hs;
      @(posedge clk); #1;
      if (out_hs) out_idx++;
      if (in_hs) in_idx++;
      cyc++;
    end
    pixel_in_TVALID = 1'b0;
    if (!aborted) begin
      check("frame_len", out_idx, NPIX);
      check("in_consumed", in_idx, 4);
      check("tvalid_after", {31'd0, pixel_out_TVALID}, 32'd0);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b0;
    pixel_in_TDATA = '0; pixel_in_TVALID = 1'b0;
    crop_Y1_TDATA = '0; crop_Y1_TVALID = 1'b0;
    crop_X1_TDATA = '0; crop_X1_TVALID = 1'b0;
    pixel_out_TREADY = 1'b1;
    clamp_exp = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_tvalid", {31'd0, pixel_out_TVALID}, 32'd0);
    check("reset_tdata",  {20'd0, pixel_out_TDATA},  32'd0);
    check("reset_tlast",  {31'd0, pixel_out_TLAST},  32'd0);
    check("reset_in_rdy", {31'd0, pixel_in_TREADY},  32'd0);
    check("reset_x_rdy",  {31'd0, crop_X1_TREADY},   32'd0);
    check("reset_y_rdy",  {31'd0, crop_Y1_TREADY},   32'd0);
    check("reset_clamp",  {31'd0, clamp_flag},       32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("release_x_rdy0", {31'd0, crop_X1_TREADY}, 32'd0);
    check("release_y_rdy0", {31'd0, crop_Y1_TREADY}, 32'd0);
    @(posedge clk); #1;
    check("release_x_rdy1", {31'd0, crop_X1_TREADY}, 32'd1);
    check("release_y_rdy1", {31'd0, crop_Y1_TREADY}, 32'd1);

    // 1: basic placement
    pix_a = '{12'd1, 12'd2, 12'd3, 12'd4};
    build_model(1, 2);
    send_corners(1, 2, 0);
    run_frame(100, 0, -1, 0);
    check("t1_clamp", {31'd0, clamp_flag}, {31'd0, clamp_exp});

    // 2: clamped corners
    rand_pix();
    build_model(9, 7);
    send_corners(9, 7, 0);
    check("t2_clamp", {31'd0, clamp_flag}, {31'd0, clamp_exp});
    run_frame(100, 0, -1, 0);

    // 3: backpressure and input gaps
    pix_a = '{12'd1, 12'd2, 12'd3, 12'd4};
    build_model(1, 2);
    send_corners(1, 2, 1);
    run_frame(50, 40, -1, 0);

    // 4: Y1 leads X1; X1 re-offered during STREAM
    rand_pix();
    build_model(1, 1);
    send_corners(1, 1, 3);
    check("t4_state_idle", {31'd0, state_dbg}, {31'd0, ST_IDLE});
    check("t4_x_rdy_drop", {31'd0, crop_X1_TREADY}, 32'd0);
    check("t4_y_rdy_drop", {31'd0, crop_Y1_TREADY}, 32'd0);
    crop_X1_TDATA  = CB'(2);
    crop_X1_TVALID = 1'b1;
    run_frame(70, 20, -1, 1);
    check("t4_x_rdy_idle", {31'd0, crop_X1_TREADY}, 32'd1);

    // 5: reset mid-frame at output index 8
    rand_pix();
    build_model(2, 1);
    send_corners(2, 1, 0);
    run_frame(100, 0, 8, 0);
    crop_X1_TVALID = 1'b0;
    crop_Y1_TVALID = 1'b0;
    clamp_exp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t5_x_rdy0", {31'd0, crop_X1_TREADY}, 32'd0);
    @(posedge clk); #1;
    check("t5_x_rdy1", {31'd0, crop_X1_TREADY}, 32'd1);
    check("t5_y_rdy1", {31'd0, crop_Y1_TREADY}, 32'd1);
    check("t5_clamp",  {31'd0, clamp_flag},     32'd0);
    rand_pix();
    build_model(4, 0);
    send_corners(4, 0, 0);
    run_frame(80, 10, -1, 0);

    // 6: back-to-back frames
    rand_pix();
    build_model(0, 0);
    send_corners(0, 0, 0);
    run_frame(100, 0, -1, 0);
    rand_pix();
    build_model(3, 2);
    send_corners(3, 2, 0);
    run_frame(100, 0, -1, 0);

    // Randomized frames
    for (int f = 0; f < 6; f++) begin
      int rx, ry;
      rx = $urandom_range(8);
      ry = $urandom_range(6);
      rand_pix();
      build_model(rx, ry);
      send_corners(rx, ry, $urandom_range(3));
      run_frame($urandom_range(100, 40), $urandom_range(50), -1, 0);
      check($sformatf("rand_clamp[%0d]", f), {31'd0, clamp_flag}, {31'd0, clamp_exp});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
